alpu_opcache: RTL and testbench

ALPU_OPCACHE -- requirements
Module: alpu_opcache

---
 rtl/alpu_opcache.sv | 149 ++++++++++++++
 tb/tb_alpu_opcache.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alpu_opcache.sv
// alpu_opcache: tagged operand cache with counted reads; ALPU_OPCACHE_BYPASS_EN enables same-cycle write-to-read bypass
module alpu_opcache #(
  parameter int DEPTH   = 4,
  parameter int NUM_WCH = 2,
  parameter int NUM_RP  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_WCH-1:0]          w_valid,
  output logic [NUM_WCH-1:0]          w_ready,
  input  logic [NUM_WCH*ADDR_W-1:0]   w_addr,
  input  logic [NUM_WCH*DATA_W-1:0]   w_data,
  input  logic [NUM_WCH*CNT_W-1:0]    w_cnt,
  input  logic [NUM_RP-1:0]           r_req,
  input  logic [NUM_RP*ADDR_W-1:0]    r_addr,
  output logic [NUM_RP*DATA_W-1:0]    r_data,
  output logic [NUM_RP-1:0]           r_hit,
  input  logic [NUM_RP-1:0]           r_consume,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic                        full,
  output logic                        empty
);
  localparam int OW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0]  v_q, v_d;
  logic [ADDR_W-1:0] a_q [DEPTH];
  logic [ADDR_W-1:0] a_d [DEPTH];
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [CNT_W-1:0]  c_q [DEPTH];
  logic [CNT_W-1:0]  c_d [DEPTH];
  logic [OW-1:0]     occ_q, occ_d;
  logic [NUM_WCH-1:0] acc;
  logic [NUM_RP-1:0] s_hit;
  logic [IW-1:0]     s_idx [NUM_RP];
`ifdef ALPU_OPCACHE_BYPASS_EN
  localparam int CW = NUM_WCH > 1 ? $clog2(NUM_WCH) : 1;
  logic [NUM_RP-1:0] b_hit;
  logic [CW-1:0]     b_ch [NUM_RP];
`endif

  assign occupancy = occ_q;
  assign full      = occ_q == OW'(DEPTH);
  assign empty     = occ_q == '0;
  assign acc       = w_valid & w_ready;

  // ready channels are the first (free entry count) channels
  always_comb
    for (int j = 0; j < NUM_WCH; j++) w_ready[j] = (DEPTH - int'(occ_q)) > j;

  // tag lookup against stored entries, then optionally against accepted writes
  always_comb begin
    for (int i = 0; i < NUM_RP; i++) begin
      s_hit[i] = 1'b0;
      s_idx[i] = '0;
      for (int e = DEPTH-1; e >= 0; e--)
        if (r_req[i] && v_q[e] && a_q[e] == r_addr[i*ADDR_W +: ADDR_W]) begin
          s_hit[i] = 1'b1;
          s_idx[i] = IW'(e);
        end
`ifdef ALPU_OPCACHE_BYPASS_EN
      b_hit[i] = 1'b0;
      b_ch[i]  = '0;
      for (int j = 0; j < NUM_WCH; j++)
        if (!s_hit[i] && r_req[i] && acc[j] && w_addr[j*ADDR_W +: ADDR_W] == r_addr[i*ADDR_W +: ADDR_W]) begin
          b_hit[i] = 1'b1;
          b_ch[i]  = CW'(j);
        end
      r_hit[i] = s_hit[i] | b_hit[i];
      r_data[i*DATA_W +: DATA_W] = s_hit[i] ? d_q[s_idx[i]] : b_hit[i] ? w_data[b_ch[i]*DATA_W +: DATA_W] : '0;
`else
      r_hit[i] = s_hit[i];
      r_data[i*DATA_W +: DATA_W] = s_hit[i] ? d_q[s_idx[i]] : '0;
`endif
    end
  end

  // next state: consumes decrement first, then writes overwrite or allocate in channel order
  always_comb begin
    int n, wc;
    logic [DEPTH-1:0] taken;
    logic found;
    v_d = v_q;
    a_d = a_q;
    d_d = d_q;
    c_d = c_q;
    taken = '0;
    for (int e = 0; e < DEPTH; e++) begin
      n = 0;
      for (int i = 0; i < NUM_RP; i++)
        if (r_consume[i] && s_hit[i] && s_idx[i] == IW'(e)) n++;
      if (n != 0) begin
        c_d[e] = int'(c_q[e]) > n ? CNT_W'(int'(c_q[e]) - n) : '0;
        if (int'(c_q[e]) <= n) v_d[e] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_WCH; j++) begin
      wc = w_cnt[j*CNT_W +: CNT_W] == '0 ? 1 : int'(w_cnt[j*CNT_W +: CNT_W]);
`ifdef ALPU_OPCACHE_BYPASS_EN
      n = 0;
      for (int i = 0; i < NUM_RP; i++)
        if (r_consume[i] && b_hit[i] && b_ch[i] == CW'(j)) n++;
      wc = wc > n ? wc - n : 0;
`endif
      found = 1'b0;
      if (acc[j]) begin
        for (int e = 0; e < DEPTH; e++)
          if (!found && (v_q[e] || taken[e]) && a_d[e] == w_addr[j*ADDR_W +: ADDR_W]) begin
            found  = 1'b1;
            d_d[e] = w_data[j*DATA_W +: DATA_W];
            c_d[e] = CNT_W'(wc);
            v_d[e] = wc != 0;
          end
        for (int e = 0; e < DEPTH; e++)
          if (!found && wc != 0 && !v_q[e] && !taken[e]) begin
            found    = 1'b1;
            taken[e] = 1'b1;
            a_d[e]   = w_addr[j*ADDR_W +: ADDR_W];
            d_d[e]   = w_data[j*DATA_W +: DATA_W];
            c_d[e]   = CNT_W'(wc);
            v_d[e]   = 1'b1;
          end
      end
    end
    occ_d = '0;
    for (int e = 0; e < DEPTH; e++) occ_d = occ_d + OW'(v_d[e]);
  end

  // entry state and occupancy registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        a_q[e] <= '0;
        d_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      a_q   <= a_d;
      d_q   <= d_d;
      c_q   <= c_d;
    end
endmodule

// File: tb/tb_alpu_opcache.sv
// tb_alpu_opcache: directed-vector bench for alpu_opcache (DEPTH=4, two write channels, two read ports)
module tb_alpu_opcache;
  logic        clk = 0;
  logic        reset_n;
  logic [1:0]  w_valid, w_ready;
  logic [15:0] w_addr;
  logic [63:0] w_data;
  logic [3:0]  w_cnt;
  logic [1:0]  r_req, r_hit, r_consume;
  logic [15:0] r_addr;
  logic [63:0] r_data;
  logic [2:0]  occupancy;
  logic        full, empty;
  int n_vec = 0, n_err = 0;

  alpu_opcache dut (
    .clk(clk), .reset_n(reset_n), .w_valid(w_valid), .w_ready(w_ready),
    .w_addr(w_addr), .w_data(w_data), .w_cnt(w_cnt), .r_req(r_req),
    .r_addr(r_addr), .r_data(r_data), .r_hit(r_hit), .r_consume(r_consume),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    w_valid = '0; w_addr = '0; w_data = '0; w_cnt = '0;
    r_req = '0; r_addr = '0; r_consume = '0;
  endtask

  task automatic wr(input int ch, input logic [7:0] a, input logic [31:0] d, input logic [1:0] c);
    w_valid[ch] = 1'b1;
    w_addr[ch*8 +: 8] = a;
    w_data[ch*32 +: 32] = d;
    w_cnt[ch*2 +: 2] = c;
  endtask

  task automatic rd(input int p, input logic [7:0] a, input logic con);
    r_req[p] = 1'b1;
    r_addr[p*8 +: 8] = a;
    r_consume[p] = con;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset_n = 0;
    rd(0, 8'h00, 1'b0);
    rd(1, 8'h00, 1'b0);
    #12;
    chk("rst_occ", occupancy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", w_ready, 2'b11);
    chk("rst_hit", r_hit, 0);
    chk("rst_data", r_data, 0);
    reset_n = 1;
    idle();
    tick();
    wr(0, 8'h12, 32'hA5A5A5A5, 2'd1);
    tick();
    idle();
    rd(0, 8'h12, 1'b0);
    #1;
    chk("w1_hit", r_hit, 2'b01);
    chk("w1_data", r_data[31:0], 32'hA5A5A5A5);
    chk("w1_occ", occupancy, 1);
    chk("w1_empty", empty, 0);
    r_consume[0] = 1'b1;
    tick();
    r_consume = '0;
    #1;
    chk("c1_hit", r_hit, 0);
    chk("c1_occ", occupancy, 0);
    chk("c1_empty", empty, 1);
    idle();
    wr(0, 8'h20, 32'h20, 2'd1);
    wr(1, 8'h21, 32'h21, 2'd1);
    tick();
    chk("half_ready", w_ready, 2'b11);
    wr(0, 8'h22, 32'h22, 2'd1);
    wr(1, 8'h23, 32'h23, 2'd1);
    tick();
    idle();
    #1;
    chk("full_flag", full, 1);
    chk("full_ready", w_ready, 2'b00);
    chk("full_occ", occupancy, 4);
    rd(0, 8'h23, 1'b0);
    rd(1, 8'h20, 1'b1);
    #1;
    chk("full_hit", r_hit, 2'b11);
    chk("full_data", r_data, {32'h20, 32'h23});
    wr(0, 8'h24, 32'h24, 2'd1);
    chk("free_same_cycle", w_ready, 2'b00);
    tick();
    idle();
    #1;
    chk("free_ready", w_ready, 2'b01);
    chk("free_occ", occupancy, 3);
    chk("free_full", full, 0);
    wr(0, 8'h24, 32'h2424, 2'd1);
    tick();
    idle();
    rd(0, 8'h24, 1'b0);
    #1;
    chk("refill_full", full, 1);
    chk("refill_data", r_data[31:0], 32'h2424);
    idle();
    wr(0, 8'h55, 32'h55, 2'd1);
    reset_n = 0;
    #1;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_ready", w_ready, 2'b11);
    tick();
    idle();
    reset_n = 1;
    rd(0, 8'h24, 1'b0);
    rd(1, 8'h55, 1'b0);
    #1;
    chk("mid_rst_hit", r_hit, 0);
    chk("mid_rst_empty", empty, 1);
    idle();
    wr(0, 8'h50, 32'h50, 2'd2);
    tick();
    idle();
    rd(0, 8'h50, 1'b1);
    rd(1, 8'h50, 1'b1);
    #1;
    chk("dual_c_hit", r_hit, 2'b11);
    tick();
    idle();
    rd(0, 8'h50, 1'b0);
    #1;
    chk("dual_c_gone", r_hit, 0);
    chk("dual_c_occ", occupancy, 0);
    idle();
    wr(0, 8'h51, 32'h51, 2'd3);
    wr(1, 8'h52, 32'h52, 2'd0);
    tick();
    idle();
    rd(0, 8'h51, 1'b1);
    rd(1, 8'h52, 1'b1);
    tick();
    idle();
    rd(0, 8'h51, 1'b0);
    rd(1, 8'h52, 1'b0);
    #1;
    chk("cnt3_cnt0", r_hit, 2'b01);
    chk("cnt3_occ", occupancy, 1);
    idle();
    wr(0, 8'h51, 32'h77, 2'd3);
    rd(0, 8'h51, 1'b1);
    rd(1, 8'h33, 1'b1);
    tick();
    idle();
    rd(0, 8'h51, 1'b1);
    rd(1, 8'h51, 1'b1);
    #1;
    chk("ovr_data", r_data, {32'h77, 32'h77});
    chk("ovr_occ", occupancy, 1);
    tick();
    idle();
    rd(0, 8'h51, 1'b1);
    #1;
    chk("ovr_left1", r_hit, 2'b01);
    tick();
    idle();
    #1;
    chk("ovr_drained", occupancy, 0);
    wr(0, 8'h30, 32'h1, 2'd1);
    wr(1, 8'h30, 32'h2, 2'd1);
    tick();
    idle();
    rd(1, 8'h30, 1'b0);
    #1;
    chk("dup_data", r_data[63:32], 32'h2);
    chk("dup_occ", occupancy, 1);
    idle();
    wr(0, 8'h40, 32'h7, 2'd1);
    rd(1, 8'h40, 1'b1);
    #1;
`ifdef ALPU_OPCACHE_BYPASS_EN
    chk("byp_hit", r_hit, 2'b10);
    chk("byp_data", r_data[63:32], 32'h7);
    tick();
    idle();
    rd(0, 8'h40, 1'b0);
    #1;
    chk("byp_occ", occupancy, 1);
    chk("byp_nostore", r_hit, 0);
`else
    chk("nobyp_hit", r_hit, 0);
    chk("nobyp_data", r_data, 0);
    tick();
    idle();
    rd(0, 8'h40, 1'b0);
    #1;
    chk("nobyp_occ", occupancy, 2);
    chk("nobyp_stored", r_data[31:0], 32'h7);
`endif
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
